// File: rtl/aes_pkg.sv
// Shared AES-128 helpers: GF(2^8) arithmetic, S-boxes, RCON and the
// forward/inverse single-step key schedule used by the iterative decryptor.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, EXPAND, ROUND, DONE} fsm_t;

  // Index 0 and 11..15 are unused; padding keeps any 4-bit index in range.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = gf_mul2(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq, res;
    sq  = a;
    res = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      res = gf_mul(res, sq);
    end
    return res;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] key_step_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0]  ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Undo one forward step: recover K_r from K_{r+1}.
  function automatic logic [127:0] key_step_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] p0, p1, p2, p3;
    p3 = k[31:0]  ^ k[63:32];
    p2 = k[63:32] ^ k[95:64];
    p1 = k[95:64] ^ k[127:96];
    p0 = k[127:96] ^ sub_rot_word(p3) ^ {rc, 24'h0};
    return {p0, p1, p2, p3};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes,
// AddRoundKey, then InvMixColumns unless this is the final round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] st_in,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] st_out
);

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {
      gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
      gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
      gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
      gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)
    };
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [31:0] col;
    // Row r of output column c comes from input column (c - r) mod 4.
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign col[31-8*r -: 8] = inv_sbox(st_in[127-8*(4*((c-r+4)%4)+r) -: 8])
                               ^ rk[127-8*(4*c+r) -: 8];
    end
    assign st_out[127-32*c -: 32] = last ? col : inv_mix_col(col);
  end

endmodule

// File: rtl/aes_128_decrypt.sv
// Iterative AES-128 decryptor: 10 cycles of forward key expansion to reach
// K10, then 10 inverse rounds that walk the key schedule backwards.
module aes_128_decrypt
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_bus,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_bus
);

  fsm_t         state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] st_q, st_d;
  logic [127:0] rk_q, rk_d;
  logic         out_valid_q, out_valid_d;

  logic [3:0]   inv_idx;
  logic         last_round;
  logic [127:0] rk_fwd, rk_inv, round_out;

  assign inv_idx    = cnt_q + 4'd1;
  assign last_round = (cnt_q == 4'd0);
  assign rk_fwd     = key_step_fwd(rk_q, RCON[cnt_q]);
  assign rk_inv     = key_step_inv(rk_q, RCON[inv_idx]);

  aes_inv_round u_round (
    .st_in  (st_q),
    .rk     (rk_inv),
    .last   (last_round),
    .st_out (round_out)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    st_d        = st_q;
    rk_d        = rk_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          st_d    = in_bus;
          rk_d    = key;
          cnt_d   = 4'd1;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        rk_d = rk_fwd;
        if (cnt_q == 4'd10) begin
          st_d    = st_q ^ rk_fwd;
          cnt_d   = 4'd9;
          state_d = ROUND;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ROUND: begin
        st_d = round_out;
        rk_d = rk_inv;
        if (last_round) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      st_q        <= '0;
      rk_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      st_q        <= st_d;
      rk_q        <= rk_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_bus   = st_q;

endmodule

// File: tb/tb_aes_128_decrypt.sv
// Scoreboard bench for aes_128_decrypt: FIPS-197 vectors, backpressure,
// mid-operation reset, input churn and loopback against a local encryptor.
module tb_aes_128_decrypt;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_bus, key, out_bus;

  int           n_cmp = 0, n_fail = 0;
  int           cyc = 0, acc_cyc = 0;
  int           or_mode = 0;
  logic [127:0] sb [$];
  logic [7:0]   sbt [256];

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  aes_128_decrypt dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bus    (in_bus),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bus   (out_bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, %0d compared / %0d mismatched", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // Independent S-box table: walk generator 3 and its inverse in lockstep.
  task automatic build_sbox();
    logic [7:0] p, q;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      sbt[p] = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4) ^ 8'h63;
    end while (p != 8'h01);
    sbt[0] = 8'h63;
  endtask

  function automatic logic [127:0] enc(input logic [127:0] pt, input logic [127:0] k_in);
    logic [127:0] s, t, k;
    logic [7:0]   rc, a0, a1, a2, a3;
    k  = k_in;
    s  = pt ^ k;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      k[127:96] = k[127:96] ^ {sbt[k[23:16]], sbt[k[15:8]], sbt[k[7:0]], sbt[k[31:24]]} ^ {rc, 24'h0};
      k[95:64]  = k[95:64] ^ k[127:96];
      k[63:32]  = k[63:32] ^ k[95:64];
      k[31:0]   = k[31:0]  ^ k[63:32];
      rc = xt(rc);
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++)
          t[127-8*(4*c+w) -: 8] = sbt[s[127-8*(4*((c+w)%4)+w) -: 8]];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          {a0, a1, a2, a3} = t[127-32*c -: 32];
          t[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                               a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                               a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                               xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
      end
      s = t ^ k;
    end
    return s;
  endfunction

  task automatic ready_drv();
    forever begin
      @(posedge clk);
      #2;
      case (or_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  endtask

  task automatic monitor();
    logic         hold = 1'b0, ov_prev = 1'b0;
    logic [127:0] hold_bus = '0, exp;
    forever begin
      @(negedge clk);
      #1;
      if (hold) begin
        chk("hold_valid", 128'(out_valid), 128'd1);
        chk("hold_bus", out_bus, hold_bus);
      end
      if (out_valid && !ov_prev) chk("latency", 128'(cyc - acc_cyc), 128'd20);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_out: got %h with empty scoreboard", out_bus);
        end else begin
          exp = sb.pop_front();
          chk("plaintext", out_bus, exp);
        end
      end
      hold     = out_valid && !out_ready && !rst;
      hold_bus = out_bus;
      ov_prev  = out_valid;
    end
  endtask

  task automatic send(input logic [127:0] c, input logic [127:0] k, input logic [127:0] p);
    int n = 0;
    @(negedge clk);
    in_bus   = c;
    key      = k;
    in_valid = 1'b1;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 128'(in_ready), 128'd1);
    sb.push_back(p);
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 128'(sb.size()), 128'd0);
  endtask

  initial begin
    logic [127:0] rk, rp;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bus    = '0;
    key       = '0;
    out_ready = 1'b1;
    build_sbox();
    fork
      monitor();
      ready_drv();
    join_none

    repeat (2) @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_bus", out_bus, 128'd0);
    chk("rst_cnt", 128'(dut.cnt_q), 128'd0);
    rst = 1'b0;

    // FIPS-197 C.1 with key-schedule endpoint check.
    send(C1_CT, C1_KEY, C1_PT);
    repeat (10) @(posedge clk);
    #1;
    chk("rk_k10", dut.rk_q, C1_K10);
    drain();

    // FIPS-197 appendix B.
    send(B_CT, B_KEY, B_PT);
    drain();

    // Backpressure with a second block waiting at the input.
    or_mode = 1;
    send(C1_CT, C1_KEY, C1_PT);
    @(negedge clk);
    in_bus   = B_CT;
    key      = B_KEY;
    in_valid = 1'b1;
    for (int n = 0; n < 40 && !out_valid; n++) @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      chk("bp_out_valid", 128'(out_valid), 128'd1);
    end
    or_mode = 0;
    send(B_CT, B_KEY, B_PT);
    chk("bp_order", 128'(sb.size()), 128'd1);
    drain();

    // Reset on the 4th ROUND cycle discards the block.
    send(C1_CT, C1_KEY, C1_PT);
    repeat (13) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_in_ready", 128'(in_ready), 128'd1);
    rst = 1'b0;
    send(C1_CT, C1_KEY, C1_PT);
    drain();

    // Inputs churn after the accept edge.
    send(C1_CT, C1_KEY, C1_PT);
    repeat (25) begin
      @(negedge clk);
      in_bus = {$urandom(), $urandom(), $urandom(), $urandom()};
      key    = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    drain();

    // Loopback through the local encryptor with random output stalls.
    or_mode = 2;
    for (int i = 0; i < 200; i++) begin
      rk = {$urandom(), $urandom(), $urandom(), $urandom()};
      rp = {$urandom(), $urandom(), $urandom(), $urandom()};
      send(enc(rp, rk), rk, rp);
    end
    drain();
    or_mode = 0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_128_decrypt.md
# aes_128_decrypt

Iterative AES-128 decryption core: takes one 128-bit ciphertext block and a 128-bit cipher key and returns the plaintext block. It is the receive-side counterpart of the fully unrolled AES-128 encryptor. It trades throughput for area by running one inverse round per clock. The forward key schedule runs on the fly, and the round keys are then regenerated in reverse, so only one 128-bit round-key register is kept.

## Interface
- No parameters; the block is fixed at AES-128 (10 rounds).
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  ciphertext and key are valid
- in_ready  out  1  core can accept a block; high only in IDLE
- in_bus  in  128  ciphertext; FIPS-197 byte order (in_bus[127:120] = byte 0, column-major)
- key  in  128  cipher key, same byte order
- out_valid  out  1  plaintext valid; held until accepted
- out_ready  in  1  downstream accepts plaintext
- out_bus  out  128  plaintext, same byte order

## Operation
- FSM states: IDLE, EXPAND, ROUND, DONE. Reset forces IDLE; any state falls to IDLE on rst.
- IDLE: in_ready=1.
  - On in_valid & in_ready, latch in_bus into st, latch key into rk, set cnt=1, and go to EXPAND.
- EXPAND, 10 cycles, cnt 1..10:
  - rk <= forward key step(rk, rcon[cnt]).
  - On cnt=10, also st <= st ^ next_rk, i.e. initial AddRoundKey with K10. Then cnt <= 9 and go to ROUND.
- ROUND, 10 cycles, r = cnt 9..0:
  - kp = inverse key step(rk, rcon[r+1]), which gives K_r.
  - st <= InvShiftRows → InvSubBytes → XOR kp → InvMixColumns. InvMixColumns is bypassed when r=0.
  - rk <= kp.
  - On r=0, go to DONE.
- DONE: out_valid=1 and out_bus=st.
  - On out_ready, go to IDLE.
  - in_ready stays 0 in DONE even if out_ready=1 in the same cycle.
- Inverse key step, with K_{r+1} = {w0,w1,w2,w3}:
  - w3' = w3^w2, w2' = w2^w1, w1' = w1^w0
  - w0' = w0 ^ SubWord(RotWord(w3')) ^ {rcon[r+1],24'h0}
- rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36. All GF(2^8) arithmetic uses modulus x^8+x^4+x^3+x+1.
- in_bus and key are sampled only on the accept edge; later changes are ignored.
- out_bus is registered. It equals st, so it holds an intermediate value outside DONE and is stable whenever out_valid=1.

## Timing
- Reset values: state=IDLE, out_valid=0, in_ready=1 (combinational from IDLE), out_bus=128'h0, cnt=0.
- Latency: if the block is accepted on edge T, out_valid first goes high after edge T+20 (10 EXPAND + 10 ROUND).
- Throughput: at most one block per 22 cycles (accept, 20 working cycles, DONE handshake, IDLE).
- The out_valid/out_ready handshake completes on any edge where both are high. Under backpressure (out_ready=0), DONE holds indefinitely and out_bus stays stable.
- rst during EXPAND, ROUND or DONE discards the block. On the next cycle state=IDLE and out_valid=0; no partial output is ever flagged valid.
- rst has priority over a simultaneous handshake.

## Structure
- Package aes_pkg holds:
  - sbox and inv_sbox functions, gf_mul2 (xtime), and the RCON constant array
  - the fsm_t enum {IDLE, EXPAND, ROUND, DONE}
  - functions key_step_fwd and key_step_inv
- Sub-module aes_inv_round is combinational: st_in, rk, last → st_out. It contains InvShiftRows, InvSubBytes, AddRoundKey and the optional InvMixColumns.
- The FSM, counter and registers live in aes_128_decrypt.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a, out_ready=1.
  - out_bus = 00112233445566778899aabbccddeeff with out_valid rising exactly 20 cycles after accept.
  - rk after EXPAND = 13111d7fe3944a17f307a78b4d2b30c5.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 → out_bus = 3243f6a8885a308d313198a2e0370734.
- Backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 and new data present.
  - out_valid and out_bus stay stable and in_ready=0.
  - The second block is accepted only after the handshake and IDLE.
- Reset mid-operation: assert rst on the 4th ROUND cycle.
  - Next cycle: out_valid=0 and in_ready=1.
  - A fresh C.1 block then decrypts correctly.
- Input churn: after accept, randomize in_bus and key every cycle → result still matches the latched block (C.1 plaintext).
- Loopback: 200 random key/plaintext pairs through the unrolled encryptor, then through aes_128_decrypt with random out_ready stalls → every output equals the original plaintext, in order.
